// File: rtl/sram_pin_responder_pkg.sv
// Shared types and constants for the SRAM pin responder.
package sram_pin_responder_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    // Legal range of the SRAM macro read latency
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 3;

    // Width of the read-latency counter (must hold RD_LAT_MAX-1)
    localparam int unsigned LAT_CNT_W  = 2;

    // Width of the completed-transaction counter
    localparam int unsigned TXN_CNT_W  = 8;

endpackage

// File: rtl/sram_pin_responder_sync_2ff.sv
// Two-flop synchronizer for one asynchronous level signal.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous level through two flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sram_pin_responder.sv
// Four-phase req/ack pin responder driving a single-port SRAM macro.
module sram_pin_responder
    import sram_pin_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic                 ack,
    output logic [DATA_W-1:0]    rdata,
    output logic                 proto_err,
    output logic [TXN_CNT_W-1:0] txn_cnt,
    output logic                 sram_ce,
    output logic                 sram_we,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic [DATA_W-1:0]    sram_wdata,
    input  logic [DATA_W-1:0]    sram_rdata
);

    // Reject unsupported macro latencies at elaboration
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("sram_pin_responder: RD_LAT out of range");
    end

    localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(RD_LAT - 1);

    state_t                 state_q, state_n;
    logic                   req_s;

    logic                   ack_q, ack_n;
    logic [DATA_W-1:0]      rdata_q, rdata_n;
    logic                   err_q, err_n;
    logic [TXN_CNT_W-1:0]   txn_q, txn_n;
    logic                   ce_q, ce_n;
    logic                   swe_q, swe_n;
    logic [ADDR_W-1:0]      addr_q, addr_n;
    logic [DATA_W-1:0]      wdata_q, wdata_n;
    logic                   we_lat_q, we_lat_n;
    logic                   abort_q, abort_n;
    logic [LAT_CNT_W-1:0]   lat_q, lat_n;

    // Only req crosses clock domains; the other inputs are held stable by protocol
    sync_2ff u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (req),
        .q     (req_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_n  = state_q;
        ack_n    = 1'b0;
        rdata_n  = rdata_q;
        err_n    = err_q;
        txn_n    = txn_q;
        ce_n     = 1'b0;
        swe_n    = 1'b0;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        we_lat_n = we_lat_q;
        abort_n  = abort_q;
        lat_n    = lat_q;

        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    state_n  = ST_ISSUE;
                    addr_n   = addr;
                    wdata_n  = wdata;
                    we_lat_n = we;
                    abort_n  = 1'b0;
                    ce_n     = 1'b1;
                    swe_n    = we;
                end
            end

            ST_ISSUE: begin
                // Early req release: finish the access but flag it
                if (!req_s) begin
                    abort_n = 1'b1;
                    err_n   = 1'b1;
                end
                lat_n = '0;
                if (we_lat_q) begin
                    state_n = ST_ACK;
                    ack_n   = 1'b1;
                end else begin
                    state_n = ST_WAIT_RD;
                end
            end

            ST_WAIT_RD: begin
                if (!req_s) begin
                    abort_n = 1'b1;
                    err_n   = 1'b1;
                end
                if (lat_q == LAT_LAST) begin
                    rdata_n = sram_rdata;
                    state_n = ST_ACK;
                    ack_n   = 1'b1;
                end else begin
                    lat_n = lat_q + 1'b1;
                end
            end

            ST_ACK: begin
                // An aborted transfer acks for a single cycle regardless of req_s
                if (!req_s || abort_q) begin
                    state_n = ST_IDLE;
                    txn_n   = txn_q + 1'b1;
                end else begin
                    ack_n = 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            txn_q    <= '0;
            ce_q     <= 1'b0;
            swe_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_lat_q <= 1'b0;
            abort_q  <= 1'b0;
            lat_q    <= '0;
        end else begin
            ack_q    <= ack_n;
            rdata_q  <= rdata_n;
            err_q    <= err_n;
            txn_q    <= txn_n;
            ce_q     <= ce_n;
            swe_q    <= swe_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            we_lat_q <= we_lat_n;
            abort_q  <= abort_n;
            lat_q    <= lat_n;
        end
    end

    assign ack        = ack_q;
    assign rdata      = rdata_q;
    assign proto_err  = err_q;
    assign txn_cnt    = txn_q;
    assign sram_ce    = ce_q;
    assign sram_we    = swe_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_sram_pin_responder.sv
// Directed bench for sram_pin_responder with a behavioural SRAM (RD_LAT=1).
module tb_sram_pin_responder;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic       ack;
    logic [7:0] rdata;
    logic       proto_err;
    logic [7:0] txn_cnt;
    logic       sram_ce;
    logic       sram_we;
    logic [5:0] sram_addr;
    logic [7:0] sram_wdata;
    logic [7:0] sram_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [64];
    int         ce_cnt = 0;
    logic       ce_we;
    logic [5:0] ce_addr;
    logic [7:0] ce_wdata;

    sram_pin_responder #(
        .ADDR_W (6),
        .DATA_W (8),
        .RD_LAT (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .ack        (ack),
        .rdata      (rdata),
        .proto_err  (proto_err),
        .txn_cnt    (txn_cnt),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: read data valid the cycle after the enable, 8'hEE otherwise
    always @(posedge clk) begin
        if (sram_ce && sram_we) mem[sram_addr] <= sram_wdata;
        sram_rdata <= (sram_ce && !sram_we) ? mem[sram_addr] : 8'hEE;
    end

    // Record every enable cycle the DUT presents to the macro
    always @(negedge clk) begin
        if (rst_n && sram_ce) begin
            ce_cnt   <= ce_cnt + 1;
            ce_we    <= sram_we;
            ce_addr  <= sram_addr;
            ce_wdata <= sram_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Count rising edges until ack reaches the given level (bounded)
    task automatic wait_ack(input logic level, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ack !== level && n < 50);
    endtask

    task automatic start_txn(input logic w, input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        we    = w;
        addr  = a;
        wdata = d;
        req   = 1'b1;
    endtask

    task automatic end_txn(output int n);
        @(negedge clk);
        req = 1'b0;
        wait_ack(1'b0, n);
    endtask

    initial begin
        int n;
        int ce_before;

        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[0]     = 8'h22;
        sram_rdata = 8'h00;
        rst_n      = 1'b0;
        req        = 1'b0;
        we         = 1'b1;
        addr       = 6'h2A;
        wdata      = 8'h5C;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",        32'(ack),        32'h0);
        check("rst_rdata",      32'(rdata),      32'h0);
        check("rst_proto_err",  32'(proto_err),  32'h0);
        check("rst_txn_cnt",    32'(txn_cnt),    32'h0);
        check("rst_sram_ce",    32'(sram_ce),    32'h0);
        check("rst_sram_we",    32'(sram_we),    32'h0);
        check("rst_sram_addr",  32'(sram_addr),  32'h0);
        check("rst_sram_wdata", 32'(sram_wdata), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Write 0x05 <- 0xA5
        start_txn(1'b1, 6'h05, 8'hA5);
        wait_ack(1'b1, n);
        check("wr_ack_rise_edges", 32'(n), 32'd4);
        check("wr_ce_count",  32'(ce_cnt),   32'd1);
        check("wr_ce_we",     32'(ce_we),    32'h1);
        check("wr_ce_addr",   32'(ce_addr),  32'h05);
        check("wr_ce_wdata",  32'(ce_wdata), 32'hA5);
        check("wr_ce_low_in_ack", 32'(sram_ce), 32'h0);
        end_txn(n);
        check("wr_ack_fall_edges", 32'(n), 32'd3);
        check("wr_txn_cnt", 32'(txn_cnt), 32'd1);

        // Read 0x05, model returns 0xA5
        start_txn(1'b0, 6'h05, 8'h00);
        wait_ack(1'b1, n);
        check("rd_ack_rise_edges", 32'(n), 32'd5);
        check("rd_rdata",    32'(rdata),  32'hA5);
        check("rd_ce_count", 32'(ce_cnt), 32'd2);
        check("rd_ce_we",    32'(ce_we),  32'h0);
        check("rd_ce_addr",  32'(ce_addr), 32'h05);
        end_txn(n);
        check("rd_ack_fall_edges", 32'(n), 32'd3);
        check("rd_txn_cnt", 32'(txn_cnt), 32'd2);

        // rdata holds across writes
        start_txn(1'b1, 6'h3F, 8'h11);
        wait_ack(1'b1, n);
        check("wr3f_ce_addr",  32'(ce_addr),  32'h3F);
        check("wr3f_ce_wdata", 32'(ce_wdata), 32'h11);
        check("wr3f_rdata_hold", 32'(rdata), 32'hA5);
        end_txn(n);
        start_txn(1'b0, 6'h00, 8'h00);
        wait_ack(1'b1, n);
        check("rd00_rdata", 32'(rdata), 32'h22);
        end_txn(n);
        start_txn(1'b1, 6'h01, 8'h33);
        wait_ack(1'b1, n);
        check("wr01_ce_wdata", 32'(ce_wdata), 32'h33);
        end_txn(n);
        repeat (3) @(posedge clk);
        #1;
        check("rdata_hold_after_write", 32'(rdata), 32'h22);
        check("txn_cnt_5", 32'(txn_cnt), 32'd5);
        check("idle_proto_err", 32'(proto_err), 32'h0);

        // Early req release on a read of 0x3F (holds 0x11)
        ce_before = ce_cnt;
        @(negedge clk);
        we   = 1'b0;
        addr = 6'h3F;
        req  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        req = 1'b0;
        n = 2;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ack !== 1'b1 && n < 50);
        check("abort_ack_rise_edges", 32'(n), 32'd5);
        check("abort_rdata", 32'(rdata), 32'h11);
        check("abort_proto_err", 32'(proto_err), 32'h1);
        check("abort_ce_count", 32'(ce_cnt - ce_before), 32'd1);
        @(posedge clk);
        #1;
        check("abort_ack_one_cycle", 32'(ack), 32'h0);
        check("abort_txn_cnt", 32'(txn_cnt), 32'd6);
        repeat (6) @(posedge clk);
        #1;
        check("abort_proto_err_sticky", 32'(proto_err), 32'h1);
        check("abort_no_reack", 32'(ack), 32'h0);

        // Reset clears sticky error and counter
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst2_proto_err", 32'(proto_err), 32'h0);
        check("rst2_txn_cnt",   32'(txn_cnt),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 256 completed transactions wrap the counter
        for (int i = 0; i < 256; i++) begin
            start_txn(1'b1, 6'h3E, 8'(i));
            wait_ack(1'b1, n);
            end_txn(n);
            if (i == 254) check("txn_cnt_255", 32'(txn_cnt), 32'd255);
        end
        check("txn_cnt_wrap", 32'(txn_cnt), 32'd0);

        // Load rdata, then reset during WAIT_RD
        start_txn(1'b0, 6'h00, 8'h00);
        wait_ack(1'b1, n);
        check("pre_rst_rdata", 32'(rdata), 32'h22);
        end_txn(n);
        check("pre_rst_txn_cnt", 32'(txn_cnt), 32'd1);
        start_txn(1'b0, 6'h05, 8'h00);
        repeat (4) @(posedge clk);
        #2;
        ce_before = ce_cnt;
        rst_n = 1'b0;
        #1;
        check("midrst_ack",        32'(ack),        32'h0);
        check("midrst_rdata",      32'(rdata),      32'h0);
        check("midrst_txn_cnt",    32'(txn_cnt),    32'h0);
        check("midrst_sram_ce",    32'(sram_ce),    32'h0);
        check("midrst_sram_addr",  32'(sram_addr),  32'h0);
        check("midrst_sram_wdata", 32'(sram_wdata), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        req   = 1'b0;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("postrst_no_ce",   32'(ce_cnt - ce_before), 32'd0);
        check("postrst_no_ack",  32'(ack),     32'h0);
        check("postrst_txn_cnt", 32'(txn_cnt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
